instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-issue instruction fetch with one-entry skid buffer,
// redirect/squash handling and jump-target operand outputs.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_stall,
  output logic [27:0] jump_index,
  output logic [3:0]  pc_hi,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        squash_q, squash_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        req;
  logic        ack;
  logic [31:0] redir_pc;

  assign req      = (state_q == FETCH);
  assign ack      = req && imem_ack;
  assign redir_pc = redirect_target & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= 32'h0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      squash_q   <= 1'b0;
      skid_q     <= 32'h0;
      skid_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      squash_q   <= squash_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    squash_d   = squash_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;

    if (redirect) begin
      // An in-flight request cannot be withdrawn: remember the target and drop its ack.
      state_d = FETCH;
      valid_d = 1'b0;
      if (ack || !req) begin
        fetch_pc_d = redir_pc;
        squash_d   = 1'b0;
      end else begin
        pend_pc_d = redir_pc;
        squash_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (valid_q && !dec_stall) valid_d = 1'b0;
          if (ack) begin
            if (squash_q) begin
              fetch_pc_d = pend_pc_q;
              squash_d   = 1'b0;
            end else begin
              fetch_pc_d = fetch_pc_q + 32'd4;
              if (!valid_q || !dec_stall) begin
                instr_d    = imem_rdata;
                instr_pc_d = fetch_pc_q;
                valid_d    = 1'b1;
              end else begin
                skid_d    = imem_rdata;
                skid_pc_d = fetch_pc_q;
                state_d   = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!dec_stall) begin
            instr_d    = skid_q;
            instr_pc_d = skid_pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign jump_index  = {instr_q[25:0], 2'b00};
  // instr_pc is word aligned, so +4 carries into bit 28 exactly when bits [27:2] are all ones.
  assign pc_hi       = instr_pc_q[31:28] + {3'b000, &instr_pc_q[27:2]};

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized scoreboard bench for instr_fetch with
// transaction-level fetch model and directed boundary scenarios.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_stall = 1'b0;
  logic [27:0] jump_index;
  logic [3:0]  pc_hi;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .dec_stall(dec_stall), .jump_index(jump_index), .pc_hi(pc_hi),
    .redirect(redirect), .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0000) return 32'h0800_0010;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_addr = RST_PC;
  logic [31:0] m_pend = 32'h0;
  logic        m_squash = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every instruction handed to decode must be the next expected word.
  always @(negedge clk) begin
    if (rst_n && instr_valid && !dec_stall && !redirect) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_instr: got pc %h with nothing expected at %0t", instr_pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr", instr, e.data);
        chk("jump_index", {4'h0, jump_index}, {4'h0, e.data[25:0], 2'b00});
        chk("pc_hi", {28'h0, pc_hi}, (e.pc + 32'd4) >> 28);
      end
    end
  end

  // One clock of stimulus; the model then applies the transaction rules for that cycle.
  task automatic cycle(input logic a, input logic s, input logic r, input logic [31:0] t);
    logic [31:0] ta;
    @(posedge clk);
    #1;
    imem_ack = a;
    dec_stall = s;
    redirect = r;
    redirect_target = t;
    @(negedge clk);
    #1;
    ta = {t[31:2], 2'b00};
    if (imem_req) chk("imem_addr", imem_addr, m_addr);
    if (r) exp_q.delete();
    if (imem_req && a) begin
      if (r) begin
        m_addr = ta;
        m_squash = 1'b0;
      end else if (m_squash) begin
        m_addr = m_pend;
        m_squash = 1'b0;
      end else begin
        exp_q.push_back('{pc: m_addr, data: mem_word(m_addr)});
        m_addr = m_addr + 32'd4;
      end
    end else if (r) begin
      if (imem_req) begin
        m_squash = 1'b1;
        m_pend = ta;
      end else begin
        m_addr = ta;
      end
    end
  endtask

  task automatic apply_reset(input logic late_ack);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dec_stall = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_jump_index", {4'h0, jump_index}, 32'h0);
    chk("rst_pc_hi", {28'h0, pc_hi}, 32'h0);
    exp_q.delete();
    m_addr = RST_PC;
    m_squash = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    imem_ack = late_ack;
  endtask

  initial begin
    logic [31:0] t;

    // Back-to-back fetch after reset, with a stale ack present while idle
    apply_reset(1'b1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0);
      chk("stream_valid", {31'h0, instr_valid}, 32'h1);
      chk("stream_pc", instr_pc, 32'(i * 4));
    end

    // Jump operands and redirect to a new target
    apply_reset(1'b0);
    cycle(0, 1, 1, 32'h1000_0000);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("j_instr", instr, 32'h0800_0010);
    chk("j_instr_pc", instr_pc, 32'h1000_0000);
    chk("j_jump_index", {4'h0, jump_index}, 32'h0000_0040);
    chk("j_pc_hi", {28'h0, pc_hi}, 32'h1);
    cycle(0, 1, 1, 32'h1000_0040);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("redir_pc", instr_pc, 32'h1000_0040);
    chk("redir_valid", {31'h0, instr_valid}, 32'h1);

    // Redirect while the request for 0x8 is outstanding
    apply_reset(1'b0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0100);
    chk("sq_addr_hold0", imem_addr, 32'h8);
    cycle(0, 0, 0, 0);
    chk("sq_addr_hold1", imem_addr, 32'h8);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("sq_new_addr", imem_addr, 32'h100);
    cycle(0, 0, 0, 0);
    chk("sq_instr_pc", instr_pc, 32'h100);
    chk("sq_valid", {31'h0, instr_valid}, 32'h1);

    // Address wrap at the top of memory
    apply_reset(1'b0);
    cycle(0, 0, 1, 32'hFFFF_FFFE);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_hi", {28'h0, pc_hi}, 32'h0);

    // Decode stall for three cycles while acks keep coming
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 0, 0);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
      chk("hold_instr", instr, exp_q[0].data);
    end
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);

    // Reset in the middle of HOLD, then restart
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("hold2_req", {31'h0, imem_req}, 32'h0);
    apply_reset(1'b1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("restart_pc", instr_pc, RST_PC);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, t);
    end

    // Drain: every accepted word must have reached decode
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    chk("drain_left", 32'(exp_q.size()), 32'h0);
    chk("drain_valid", {31'h0, instr_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
